// File: rtl/scm_fifo_pkg.sv
// scm_fifo_pkg: shared types and sizing helpers for scm_fifo_ctrl.
//   skid_state_e : output skid buffer occupancy state (value equals words held)
//   fifo_depth   : memory depth for a given address width
//   count_width  : COUNT width, memory depth plus the two skid entries
package scm_fifo_pkg;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } skid_state_e;

    localparam int CNT_EXTRA = 2;

    function automatic int fifo_depth(input int aw);
        return 1 << aw;
    endfunction

    function automatic int count_width(input int aw);
        return aw + CNT_EXTRA;
    endfunction

endpackage

// File: rtl/scm_fifo_skid.sv
// scm_fifo_skid: 2-entry output skid buffer fed by the scm65 read port.
//   CLK, RSTN  : clock, asynchronous active-low reset
//   capture    : MEM_DOUT holds a word issued last cycle; take it now
//   din        : word to capture
//   pop        : consumer takes the head entry this cycle
//   out_valid  : head entry is valid
//   occ        : entries held (0..2)
//   out_data   : head entry, stable until popped
module scm_fifo_skid
    import scm_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 64
)(
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  capture,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  pop,
    output logic                  out_valid,
    output logic [1:0]            occ,
    output logic [DATA_WIDTH-1:0] out_data
);

    skid_state_e state, state_nxt;
    logic [DATA_WIDTH-1:0] spill;

    always_ff @(posedge CLK or negedge RSTN)
        if (!RSTN) state <= S_EMPTY;
        else state <= state_nxt;

    // Capture while S_TWO is excluded by the read-issue rule upstream.
    always_comb begin
        state_nxt = state;
        case (state)
            S_EMPTY: state_nxt = capture ? S_ONE : S_EMPTY;
            S_ONE:   state_nxt = (capture && !pop) ? S_TWO : (!capture && pop) ? S_EMPTY : S_ONE;
            default: state_nxt = pop ? S_ONE : S_TWO;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN)
        if (!RSTN) begin
            out_data <= '0;
            spill    <= '0;
        end else begin
            if (state == S_TWO && pop) out_data <= spill;
            else if (capture && (state == S_EMPTY || pop)) out_data <= din;
            if (state == S_ONE && capture && !pop) spill <= din;
        end

    assign out_valid = state != S_EMPTY;
    assign occ       = state;

endmodule

// File: rtl/scm_fifo_ctrl.sv
// scm_fifo_ctrl: valid/ready FIFO controller wrapped around the scm65 standard-cell memory.
//   CLK, RSTN            : clock, asynchronous active-low reset
//   IN_VALID/READY/DATA  : push interface
//   OUT_VALID/READY/DATA : pop interface, head word from the skid buffer
//   MEM_WE/WADDR/DIN     : scm65 write port
//   MEM_RE/RADDR/DOUT    : scm65 read port, 1-cycle read latency
//   MEM_SE               : scm65 scan enable, tied low
//   COUNT                : words held in memory, read pipeline and skid buffer
//   FULL, EMPTY          : memory rows all used / COUNT == 0
//   HWM                  : peak COUNT since reset, present only with SCM_FIFO_HWM_EN defined
module scm_fifo_ctrl
    import scm_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 64
)(
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic [DATA_WIDTH-1:0] IN_DATA,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [DATA_WIDTH-1:0] OUT_DATA,
    output logic                  MEM_WE,
    output logic [ADDR_WIDTH-1:0] MEM_WADDR,
    output logic [DATA_WIDTH-1:0] MEM_DIN,
    output logic                  MEM_RE,
    output logic [ADDR_WIDTH-1:0] MEM_RADDR,
    input  logic [DATA_WIDTH-1:0] MEM_DOUT,
    output logic                  MEM_SE,
    output logic [ADDR_WIDTH+1:0] COUNT,
    output logic                  FULL,
`ifdef SCM_FIFO_HWM_EN
    output logic [ADDR_WIDTH+1:0] HWM,
`endif
    output logic                  EMPTY
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);
    localparam int CW    = count_width(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);

    logic [ADDR_WIDTH:0] wptr, rptr, mem_cnt;
    logic [1:0] occ;
    logic inflight, push, pop, room;

    assign mem_cnt  = wptr - rptr;
    assign FULL     = mem_cnt == FULL_CNT;
    assign IN_READY = !FULL;
    // RSTN gate drops the write strobe as soon as reset asserts.
    assign push     = IN_VALID && IN_READY && RSTN;
    assign pop      = OUT_VALID && OUT_READY;
    // Skid slots not yet claimed by held or in-flight words; a pop this cycle
    // frees one in time for the capture, which sustains one word per cycle.
    assign room     = occ == 2'd0 || (occ == 2'd1 && !inflight) || pop;

    assign MEM_WE    = push;
    assign MEM_WADDR = wptr[ADDR_WIDTH-1:0];
    assign MEM_DIN   = IN_DATA;
    assign MEM_RE    = mem_cnt != '0 && room;
    assign MEM_RADDR = rptr[ADDR_WIDTH-1:0];
    assign MEM_SE    = 1'b0;
    assign EMPTY     = COUNT == '0;

    always_ff @(posedge CLK or negedge RSTN)
        if (!RSTN) begin
            wptr     <= '0;
            rptr     <= '0;
            inflight <= 1'b0;
            COUNT    <= '0;
        end else begin
            if (push) wptr <= wptr + (ADDR_WIDTH+1)'(1);
            if (MEM_RE) rptr <= rptr + (ADDR_WIDTH+1)'(1);
            inflight <= MEM_RE;
            if (push != pop) COUNT <= push ? COUNT + CW'(1) : COUNT - CW'(1);
        end

`ifdef SCM_FIFO_HWM_EN
    always_ff @(posedge CLK or negedge RSTN)
        if (!RSTN) HWM <= '0;
        else if (COUNT > HWM) HWM <= COUNT;
`endif

    scm_fifo_skid #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .capture   (inflight),
        .din       (MEM_DOUT),
        .pop       (pop),
        .out_valid (OUT_VALID),
        .occ       (occ),
        .out_data  (OUT_DATA)
    );

endmodule

// File: tb/tb_scm_fifo_ctrl.sv
// tb_scm_fifo_ctrl: directed bench for scm_fifo_ctrl with a behavioural scm65 model.
module tb_scm_fifo_ctrl;

    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [63:0] IN_DATA = '0;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b0;
    logic [63:0] OUT_DATA;
    logic        MEM_WE;
    logic [5:0]  MEM_WADDR;
    logic [63:0] MEM_DIN;
    logic        MEM_RE;
    logic [5:0]  MEM_RADDR;
    logic [63:0] MEM_DOUT;
    logic        MEM_SE;
    logic [7:0]  COUNT;
    logic        FULL;
    logic        EMPTY;
`ifdef SCM_FIFO_HWM_EN
    logic [7:0]  HWM;
`endif

    scm_fifo_ctrl #(.ADDR_WIDTH(6), .DATA_WIDTH(64)) dut (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .IN_DATA   (IN_DATA),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_DATA  (OUT_DATA),
        .MEM_WE    (MEM_WE),
        .MEM_WADDR (MEM_WADDR),
        .MEM_DIN   (MEM_DIN),
        .MEM_RE    (MEM_RE),
        .MEM_RADDR (MEM_RADDR),
        .MEM_DOUT  (MEM_DOUT),
        .MEM_SE    (MEM_SE),
        .COUNT     (COUNT),
        .FULL      (FULL),
`ifdef SCM_FIFO_HWM_EN
        .HWM       (HWM),
`endif
        .EMPTY     (EMPTY)
    );

    always #5 CLK = ~CLK;

    // scm65 behavioural model: synchronous write, registered 1-cycle read.
    logic [63:0] mem [0:63];
    always @(posedge CLK) begin
        if (MEM_WE) mem[MEM_WADDR] <= MEM_DIN;
        if (MEM_RE) MEM_DOUT <= mem[MEM_RADDR];
    end

    int tests = 0;
    int fails = 0;
    int exp_count = 0;
    logic [63:0] sb [$];
    logic acc, pop_ev;
    logic [63:0] got_d, exp_d;

    // Inputs change at the falling edge; outputs are sampled 1 time unit later.
    task automatic drive(input logic iv, input logic [63:0] d, input logic ordy);
        @(negedge CLK);
        IN_VALID  = iv;
        IN_DATA   = d;
        OUT_READY = ordy;
        #1;
    endtask

    // Record this cycle's handshakes in the model, then cross the rising edge.
    task automatic commit();
        acc    = IN_VALID && IN_READY;
        pop_ev = OUT_VALID && OUT_READY;
        got_d  = OUT_DATA;
        exp_d  = '0;
        if (pop_ev) exp_d = (sb.size() > 0) ? sb.pop_front() : ~OUT_DATA;
        if (acc) sb.push_back(IN_DATA);
        exp_count += int'(acc) - int'(pop_ev);
        @(posedge CLK);
    endtask

    task automatic model_reset();
        sb.delete();
        exp_count = 0;
    endtask

    task automatic test_reset();
        RSTN = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RSTN = 1'b1;
        model_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            #1;
            tests++;
            if ({EMPTY, FULL, COUNT, OUT_VALID, MEM_WE, MEM_RE, MEM_SE} !== {1'b1, 1'b0, 8'd0, 4'b0000}) begin
                fails++;
                $display("FAIL reset_idle cyc=%0d got E=%b F=%b C=%0d OV=%b WE=%b RE=%b SE=%b want E=1 F=0 C=0 OV=0 WE=0 RE=0 SE=0",
                         i, EMPTY, FULL, COUNT, OUT_VALID, MEM_WE, MEM_RE, MEM_SE);
            end
        end
    endtask

    task automatic test_single();
        logic [63:0] d = 64'hDEADBEEF_01234567;
        drive(1'b1, d, 1'b1);
        tests++;
        if ({MEM_WE, MEM_WADDR, MEM_DIN, MEM_RE, IN_READY} !== {1'b1, 6'd0, d, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL single_c0 got WE=%b WADDR=%0d DIN=%h RE=%b IR=%b want WE=1 WADDR=0 DIN=%h RE=0 IR=1",
                     MEM_WE, MEM_WADDR, MEM_DIN, MEM_RE, IN_READY, d);
        end
        commit();
        drive(1'b0, '0, 1'b1);
        tests++;
        if ({MEM_RE, MEM_RADDR, MEM_WE, OUT_VALID} !== {1'b1, 6'd0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL single_c1 got RE=%b RADDR=%0d WE=%b OV=%b want RE=1 RADDR=0 WE=0 OV=0",
                     MEM_RE, MEM_RADDR, MEM_WE, OUT_VALID);
        end
        commit();
        drive(1'b0, '0, 1'b1);
        tests++;
        if (OUT_VALID !== 1'b0) begin
            fails++;
            $display("FAIL single_c2 got OV=%b want OV=0", OUT_VALID);
        end
        commit();
        drive(1'b0, '0, 1'b1);
        tests++;
        if ({OUT_VALID, OUT_DATA} !== {1'b1, d}) begin
            fails++;
            $display("FAIL single_c3 got OV=%b DATA=%h want OV=1 DATA=%h", OUT_VALID, OUT_DATA, d);
        end
        commit();
        drive(1'b0, '0, 1'b0);
        tests++;
        if ({EMPTY, COUNT, OUT_VALID} !== {1'b1, 8'd0, 1'b0}) begin
            fails++;
            $display("FAIL single_after got E=%b C=%0d OV=%b want E=1 C=0 OV=0", EMPTY, COUNT, OUT_VALID);
        end
        commit();
    endtask

    task automatic test_fill();
        int n = 0;
        for (int i = 0; i < 66; i++) begin
            drive(1'b1, {$urandom(), $urandom()}, 1'b0);
            commit();
            n += int'(acc);
        end
        tests++;
        if (n !== 66) begin
            fails++;
            $display("FAIL fill_accepts got %0d want 66", n);
        end
        drive(1'b1, {$urandom(), $urandom()}, 1'b0);
        tests++;
        if ({COUNT, FULL, IN_READY, MEM_WE} !== {8'd66, 1'b1, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL fill_full got C=%0d F=%b IR=%b WE=%b want C=66 F=1 IR=0 WE=0", COUNT, FULL, IN_READY, MEM_WE);
        end
        tests++;
        if ({OUT_VALID, OUT_DATA} !== {1'b1, sb[0]}) begin
            fails++;
            $display("FAIL fill_head got OV=%b DATA=%h want OV=1 DATA=%h", OUT_VALID, OUT_DATA, sb[0]);
        end
        commit();
    endtask

    task automatic test_drain_wrap();
        for (int i = 0; i < 200; i++) begin
            drive(1'b1, {$urandom(), $urandom()}, 1'b1);
            commit();
            tests++;
            if (!pop_ev || got_d !== exp_d) begin
                fails++;
                $display("FAIL drain cyc=%0d got pop=%b data=%h want pop=1 data=%h", i, pop_ev, got_d, exp_d);
            end
        end
        drive(1'b0, '0, 1'b0);
        tests++;
        if (COUNT !== 8'(exp_count)) begin
            fails++;
            $display("FAIL drain_count got %0d want %0d", COUNT, exp_count);
        end
        commit();
    endtask

    task automatic test_backpressure();
        logic stall = 1'b0;
        logic [63:0] stall_d = '0;
        for (int i = 0; i < 2000; i++) begin
            drive(1'($urandom_range(0, 1)), {$urandom(), $urandom()}, 1'($urandom_range(0, 1)));
            tests++;
            if (COUNT !== 8'(exp_count)) begin
                fails++;
                $display("FAIL bp_count cyc=%0d got %0d want %0d", i, COUNT, exp_count);
            end
            if (stall) begin
                tests++;
                if ({OUT_VALID, OUT_DATA} !== {1'b1, stall_d}) begin
                    fails++;
                    $display("FAIL bp_stall cyc=%0d got OV=%b DATA=%h want OV=1 DATA=%h", i, OUT_VALID, OUT_DATA, stall_d);
                end
            end
            stall   = OUT_VALID && !OUT_READY;
            stall_d = OUT_DATA;
            commit();
            if (pop_ev) begin
                tests++;
                if (got_d !== exp_d) begin
                    fails++;
                    $display("FAIL bp_order cyc=%0d got %h want %h", i, got_d, exp_d);
                end
            end
        end
    endtask

    task automatic test_midstream_reset();
        logic [63:0] fresh = 64'hC0FFEE00_5A5AA5A5;
        logic seen = 1'b0;
        RSTN = 1'b0;
        IN_VALID = 1'b0;
        OUT_READY = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RSTN = 1'b1;
        model_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, {$urandom(), $urandom()}, 1'b0);
            commit();
        end
        drive(1'b0, '0, 1'b0);
        commit();
        drive(1'b1, 64'h1234, 1'b1);
        tests++;
        if ({COUNT, MEM_WE, MEM_RE, OUT_VALID} !== {8'd20, 1'b1, 1'b1, 1'b1}) begin
            fails++;
            $display("FAIL mid_pre got C=%0d WE=%b RE=%b OV=%b want C=20 WE=1 RE=1 OV=1", COUNT, MEM_WE, MEM_RE, OUT_VALID);
        end
`ifdef SCM_FIFO_HWM_EN
        tests++;
        if (HWM !== 8'd20) begin
            fails++;
            $display("FAIL hwm_pre got %0d want 20", HWM);
        end
`endif
        RSTN = 1'b0;
        #1;
        tests++;
        if ({OUT_VALID, COUNT, EMPTY, MEM_WE, MEM_RE} !== {1'b0, 8'd0, 1'b1, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL mid_reset got OV=%b C=%0d E=%b WE=%b RE=%b want OV=0 C=0 E=1 WE=0 RE=0",
                     OUT_VALID, COUNT, EMPTY, MEM_WE, MEM_RE);
        end
`ifdef SCM_FIFO_HWM_EN
        tests++;
        if (HWM !== 8'd0) begin
            fails++;
            $display("FAIL hwm_post got %0d want 0", HWM);
        end
`endif
        IN_VALID = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RSTN = 1'b1;
        model_reset();
        drive(1'b1, fresh, 1'b1);
        commit();
        for (int i = 0; i < 8 && !seen; i++) begin
            drive(1'b0, '0, 1'b1);
            commit();
            seen = pop_ev;
        end
        tests++;
        if (!seen || got_d !== fresh) begin
            fails++;
            $display("FAIL mid_fresh got seen=%b data=%h want seen=1 data=%h", seen, got_d, fresh);
        end
        drive(1'b0, '0, 1'b0);
        tests++;
        if ({EMPTY, COUNT} !== {1'b1, 8'd0}) begin
            fails++;
            $display("FAIL mid_empty got E=%b C=%0d want E=1 C=0", EMPTY, COUNT);
        end
        commit();
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_drain_wrap();
        test_backpressure();
        test_midstream_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
